ysyx_041514_muldiv_ctrl: RTL and testbench

YSYX_041514_MULDIV_CTRL -- requirements
Module: ysyx_041514_muldiv_ctrl

---
 rtl/ysyx_041514_muldiv_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_041514_muldiv_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041514_muldiv_ctrl.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define YSYX_041514_MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiply in one cycle.

module ysyx_041514_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic        req_word_i,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  input  logic        flush_i,
  input  logic        result_ready_i,
  output logic        stall_req_o,
  output logic        result_valid_o,
  output logic [63:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic   accept, last, take_early;

  logic        is_div, word_ok, s1_signed, s2_signed;
  logic [63:0] a_ext, b_ext, mag_a, mag_b, early_res;
  logic        neg_a, neg_b, b_zero;

  logic [2:0]   op_q;
  logic         word_q, neg_res_q, neg_rem_q, div_zero_q;
  logic [5:0]   cnt_q;
  logic [127:0] acc_q, mcand_q;
  logic [63:0]  mplier_q, rem_q, quo_q, dvsr_q, result_q;

  logic [127:0] acc_n, prod;
  logic [64:0]  div_shift;
  logic [63:0]  rem_n, quo_n, quo_fix, rem_fix, res_full, res_final;

  // W forms only exist for MUL and the divides; other ops ignore req_word_i.
  assign is_div    = req_op_i[2];
  assign word_ok   = req_word_i & ((req_op_i == 3'd0) | req_op_i[2]);
  assign s1_signed = (req_op_i == 3'd1) | (req_op_i == 3'd2) | (req_op_i == 3'd4) | (req_op_i == 3'd6);
  assign s2_signed = (req_op_i == 3'd1) | (req_op_i == 3'd4) | (req_op_i == 3'd6);

  assign a_ext  = word_ok ? {{32{s1_signed & src1_i[31]}}, src1_i[31:0]} : src1_i;
  assign b_ext  = word_ok ? {{32{s2_signed & src2_i[31]}}, src2_i[31:0]} : src2_i;
  assign neg_a  = s1_signed & a_ext[63];
  assign neg_b  = s2_signed & b_ext[63];
  assign mag_a  = neg_a ? (~a_ext + 64'd1) : a_ext;
  assign mag_b  = neg_b ? (~b_ext + 64'd1) : b_ext;
  assign b_zero = (b_ext == 64'd0);

`ifdef YSYX_041514_MULDIV_EARLY_OUT_EN
  logic        a_zero, sgn_ovf;
  logic [63:0] div_a_w, min_val;

  assign a_zero     = (a_ext == 64'd0);
  assign div_a_w    = word_ok ? {{32{src1_i[31]}}, src1_i[31:0]} : src1_i;
  assign min_val    = word_ok ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign sgn_ovf    = is_div & s2_signed & (a_ext == min_val) & (&b_ext);
  assign take_early = is_div ? (b_zero | sgn_ovf) : (a_zero | b_zero);

  always_comb begin
    early_res = 64'd0;
    if (is_div & b_zero)
      early_res = req_op_i[1] ? div_a_w : {64{1'b1}};
    else if (sgn_ovf)
      early_res = req_op_i[1] ? 64'd0 : div_a_w;
  end
`else
  assign take_early = 1'b0;
  assign early_res  = 64'd0;
`endif

  assign last = (cnt_q == (word_q ? 6'd31 : 6'd63));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    stall_req_o    = 1'b0;
    result_valid_o = 1'b0;
    busy_o         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        stall_req_o = req_valid_i & rst;
        if (req_valid_i & ~flush_i) begin
          accept  = 1'b1;
          state_d = take_early ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_req_o = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        stall_req_o    = ~result_ready_i;
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d        = IDLE;
      stall_req_o    = 1'b0;
      result_valid_o = 1'b0;
    end
  end

  // The result is formed from the post-iteration values so it lands in result_q on the BUSY->DONE edge.
  always_comb begin
    acc_n     = acc_q + (mplier_q[0] ? mcand_q : 128'd0);
    div_shift = {rem_q, quo_q[63]};
    if (div_shift >= {1'b0, dvsr_q}) begin
      rem_n = div_shift[63:0] - dvsr_q;
      quo_n = {quo_q[62:0], 1'b1};
    end else begin
      rem_n = div_shift[63:0];
      quo_n = {quo_q[62:0], 1'b0};
    end
    prod    = neg_res_q ? (~acc_n + 128'd1) : acc_n;
    quo_fix = (neg_res_q & ~div_zero_q) ? (~quo_n + 64'd1) : quo_n;
    rem_fix = neg_rem_q ? (~rem_n + 64'd1) : rem_n;
    case (op_q)
      3'd0:                res_full = prod[63:0];
      3'd1, 3'd2, 3'd3:    res_full = prod[127:64];
      3'd4, 3'd5:          res_full = quo_fix;
      default:             res_full = rem_fix;
    endcase
    res_final = word_q ? {{32{res_full[31]}}, res_full[31:0]} : res_full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= 3'd0;
      word_q     <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= 6'd0;
      acc_q      <= 128'd0;
      mcand_q    <= 128'd0;
      mplier_q   <= 64'd0;
      rem_q      <= 64'd0;
      quo_q      <= 64'd0;
      dvsr_q     <= 64'd0;
      result_q   <= 64'd0;
    end else if (accept) begin
      op_q       <= req_op_i;
      word_q     <= word_ok;
      neg_res_q  <= neg_a ^ neg_b;
      neg_rem_q  <= neg_a;
      div_zero_q <= is_div & b_zero;
      cnt_q      <= 6'd0;
      acc_q      <= 128'd0;
      mcand_q    <= {64'd0, mag_a};
      mplier_q   <= mag_b;
      rem_q      <= 64'd0;
      quo_q      <= word_ok ? {mag_a[31:0], 32'd0} : mag_a;
      dvsr_q     <= mag_b;
      if (take_early) result_q <= early_res;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 6'd1;
      if (op_q[2]) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
      end else begin
        acc_q    <= acc_n;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (last && !flush_i) result_q <= res_final;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_ysyx_041514_muldiv_ctrl.sv
// Randomized self-checking bench for ysyx_041514_muldiv_ctrl against an arithmetic reference model.
// Honours YSYX_041514_MULDIV_EARLY_OUT_EN for expected latencies.

module tb_ysyx_041514_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [2:0]  req_op_i;
  logic        req_word_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic        flush_i;
  logic        result_ready_i;
  logic        stall_req_o;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic        busy_o;

  int vector_count = 0;
  int miscompare_count = 0;

`ifdef YSYX_041514_MULDIV_EARLY_OUT_EN
  localparam bit EarlyEn = 1'b1;
`else
  localparam bit EarlyEn = 1'b0;
`endif

  ysyx_041514_muldiv_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_op_i       (req_op_i),
    .req_word_i     (req_word_i),
    .src1_i         (src1_i),
    .src2_i         (src2_i),
    .flush_i        (flush_i),
    .result_ready_i (result_ready_i),
    .stall_req_o    (stall_req_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] refResult(input logic [2:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
    logic               w;
    logic signed [127:0] sa, sb, sp;
    logic [127:0]       up;
    logic signed [63:0] x, y;
    logic signed [31:0] x32, y32;
    logic [31:0]        ua32, ub32, r32;
    logic [63:0]        r;
    w    = word && (op == 3'd0 || op[2]);
    sa   = $signed({{64{a[63]}}, a});
    sb   = $signed({{64{b[63]}}, b});
    x    = a;
    y    = b;
    x32  = a[31:0];
    y32  = b[31:0];
    ua32 = a[31:0];
    ub32 = b[31:0];
    r    = 64'd0;
    r32  = 32'd0;
    case (op)
      3'd0: begin up = {64'd0, a} * {64'd0, b}; r = w ? sext32(up[31:0]) : up[63:0]; end
      3'd1: begin sp = sa * sb; r = sp[127:64]; end
      3'd2: begin sp = sa * $signed({64'd0, b}); r = sp[127:64]; end
      3'd3: begin up = {64'd0, a} * {64'd0, b}; r = up[127:64]; end
      3'd4: begin
        if (w) begin
          if (y32 == 0) r32 = 32'hFFFF_FFFF;
          else if (x32 == 32'sh8000_0000 && y32 == -32'sd1) r32 = x32;
          else r32 = x32 / y32;
          r = sext32(r32);
        end else begin
          if (y == 0) r = 64'hFFFF_FFFF_FFFF_FFFF;
          else if (x == 64'sh8000_0000_0000_0000 && y == -64'sd1) r = x;
          else r = x / y;
        end
      end
      3'd5: begin
        if (w) r = (ub32 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : sext32(ua32 / ub32);
        else   r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      end
      3'd6: begin
        if (w) begin
          if (y32 == 0) r32 = x32;
          else if (x32 == 32'sh8000_0000 && y32 == -32'sd1) r32 = 32'd0;
          else r32 = x32 % y32;
          r = sext32(r32);
        end else begin
          if (y == 0) r = x;
          else if (x == 64'sh8000_0000_0000_0000 && y == -64'sd1) r = 64'd0;
          else r = x % y;
        end
      end
      default: begin
        if (w) r = (ub32 == 0) ? sext32(ua32) : sext32(ua32 % ub32);
        else   r = (b == 0) ? a : a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic word,
                                    input logic [63:0] a, input logic [63:0] b);
    logic w, early, dz, ovf;
    w = word && (op == 3'd0 || op[2]);
    if (op[2]) begin
      dz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf = (op == 3'd4 || op == 3'd6) &&
            (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
               : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
      early = dz || ovf;
    end else begin
      early = w ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
    end
    return (EarlyEn && early) ? 1 : (w ? 33 : 65);
  endfunction

  function automatic logic [63:0] pickOperand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      4:       return {32'd0, $urandom};
      5:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic word,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp_res, input int exp_lat,
                               input int ready_delay, input bit noisy);
    int          lat;
    bit          stall_ok, hold_ok;
    logic [63:0] held;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_word_i  = word;
    src1_i      = a;
    src2_i      = b;
    #1 stall_ok = stall_req_o;
    @(posedge clk); #1;
    if (noisy) begin
      src1_i   = {$urandom, $urandom};
      src2_i   = {$urandom, $urandom};
      req_op_i = 3'($urandom_range(0, 7));
    end else begin
      req_valid_i = 1'b0;
    end
    lat = 1;
    while (!result_valid_o && lat < 200) begin
      if (!stall_req_o) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    req_valid_i = 1'b0;
    checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, ".result"}, result_o, exp_res);
    held    = result_o;
    hold_ok = 1'b1;
    repeat (ready_delay) begin
      if (!stall_req_o) stall_ok = 1'b0;
      @(posedge clk); #1;
      if (result_o !== held || result_valid_o !== 1'b1) hold_ok = 1'b0;
    end
    if (!stall_req_o) stall_ok = 1'b0;
    checkOutput({tag, ".stall_held"}, 64'(stall_ok), 64'd1);
    if (ready_delay > 0) checkOutput({tag, ".hold_stable"}, 64'(hold_ok), 64'd1);
    result_ready_i = 1'b1;
    #1 checkOutput({tag, ".stall_drop"}, 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    result_ready_i = 1'b0;
    checkOutput({tag, ".idle_after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic        word;
    logic [63:0] a, b;
    bit          valid_seen;
    int          div_lat;

    rst            = 1'b0;
    req_valid_i    = 1'b1;
    req_op_i       = 3'd0;
    req_word_i     = 1'b0;
    src1_i         = 64'd3;
    src2_i         = 64'd4;
    flush_i        = 1'b0;
    result_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.stall", 64'(stall_req_o), 64'd0);
    checkOutput("reset.valid", 64'(result_valid_o), 64'd0);
    checkOutput("reset.result", result_o, 64'd0);
    checkOutput("reset.busy", 64'(busy_o), 64'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    div_lat = EarlyEn ? 1 : 65;
    applyStimulus("mul_7xm3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 3, 1'b0);
    applyStimulus("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0, 1'b0);
    applyStimulus("div_by0", 3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, div_lat, 1, 1'b0);
    applyStimulus("rem_by0", 3'd6, 1'b0, 64'd5, 64'd0, 64'd5, div_lat, 0, 1'b0);
    applyStimulus("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, div_lat, 0, 1'b0);
    applyStimulus("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd0, div_lat, 0, 1'b0);
    applyStimulus("divu_noisy", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 2, 1'b1);
    applyStimulus("remu", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0, 1'b0);
    applyStimulus("mulhu_max", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFE, 65, 0, 1'b0);

    // Flush at the tenth BUSY cycle: stall drops at once, no result ever appears.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 3'd0;
    req_word_i  = 1'b0;
    src1_i      = 64'd3;
    src2_i      = 64'd5;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    #1 checkOutput("flush.stall", 64'(stall_req_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush.idle", 64'(busy_o), 64'd0);
    valid_seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (result_valid_o) valid_seen = 1'b1;
    end
    checkOutput("flush.no_valid", 64'(valid_seen), 64'd0);

    // Reset mid-operation discards the work in flight.
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = 3'd5;
    src1_i      = 64'd1000;
    src2_i      = 64'd3;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checkOutput("midreset.busy", 64'(busy_o), 64'd0);
    checkOutput("midreset.stall", 64'(stall_req_o), 64'd0);
    checkOutput("midreset.result", result_o, 64'd0);
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    valid_seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (result_valid_o || busy_o) valid_seen = 1'b1;
    end
    checkOutput("midreset.no_valid", 64'(valid_seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      word = 1'($urandom_range(0, 1));
      a    = pickOperand();
      b    = pickOperand();
      applyStimulus($sformatf("rand%0d_op%0d_w%0d", i, op, word), op, word, a, b,
                    refResult(op, word, a, b), expLatency(op, word, a, b),
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
